// File: rtl/hour_counter.sv
// BCD hours counter with a set/ack load handshake; 24-hour by default,
// 12-hour AM/PM mode (adds pm/set_pm ports) when HOUR_12H_EN is defined.
module hour_counter #(
  parameter logic [7:0] START_HOURS = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       set_req,
  input  logic [7:0] set_hours,
`ifdef HOUR_12H_EN
  input  logic       set_pm,
  output logic       pm,
`endif
  output logic       set_ack,
  output logic       set_err,
  output logic [7:0] count,
  output logic       day_wrap
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_REL} state_t;

`ifdef HOUR_12H_EN
  // 00 is not a legal 12-hour value, so the default start maps to 12 AM
  localparam logic [7:0] RST_HOURS = (START_HOURS == 8'h00) ? 8'h12 : START_HOURS;
`else
  localparam logic [7:0] RST_HOURS = START_HOURS;
`endif

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       day_wrap_q, day_wrap_d;
  logic [7:0] inc_count;
  logic       inc_wrap;
  logic       set_legal;

  logic [3:0] tens, units, set_tens, set_units;
  assign tens      = count_q[7:4];
  assign units     = count_q[3:0];
  assign set_tens  = set_hours[7:4];
  assign set_units = set_hours[3:0];

`ifdef HOUR_12H_EN
  logic pm_q, pm_d, inc_pm;

  always_comb begin
    set_legal = ((set_tens == 4'd0) && (set_units >= 4'd1) && (set_units <= 4'd9)) ||
                ((set_tens == 4'd1) && (set_units <= 4'd2));
  end

  always_comb begin
    inc_count = count_q;
    inc_pm    = pm_q;
    inc_wrap  = 1'b0;
    if (count_q == 8'h12) begin
      inc_count = 8'h01;
    end else if (count_q == 8'h11) begin
      inc_count = 8'h12;
      inc_pm    = ~pm_q;
      inc_wrap  = pm_q;
    end else if (units == 4'd9) begin
      inc_count = {tens + 4'd1, 4'd0};
    end else begin
      inc_count = {tens, units + 4'd1};
    end
  end

  assign pm = pm_q;
`else
  always_comb begin
    set_legal = ((set_tens <= 4'd1) && (set_units <= 4'd9)) ||
                ((set_tens == 4'd2) && (set_units <= 4'd3));
  end

  always_comb begin
    inc_count = count_q;
    inc_wrap  = 1'b0;
    if (count_q == 8'h23) begin
      inc_count = 8'h00;
      inc_wrap  = 1'b1;
    end else if (units == 4'd9) begin
      inc_count = {tens + 4'd1, 4'd0};
    end else begin
      inc_count = {tens, units + 4'd1};
    end
  end
`endif

  // A load cycle owns the count register; any hour carry seen then is discarded
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    day_wrap_d = 1'b0;
    set_ack    = 1'b0;
    set_err    = 1'b0;
`ifdef HOUR_12H_EN
    pm_d       = pm_q;
`endif
    case (state_q)
      IDLE: begin
        if (set_req) state_d = LOAD;
      end
      LOAD: begin
        set_ack = 1'b1;
        set_err = ~set_legal;
        if (set_legal) begin
          count_d = set_hours;
`ifdef HOUR_12H_EN
          pm_d    = set_pm;
`endif
        end
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!set_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != LOAD) && en) begin
      count_d    = inc_count;
      day_wrap_d = inc_wrap;
`ifdef HOUR_12H_EN
      pm_d       = inc_pm;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= RST_HOURS;
      day_wrap_q <= 1'b0;
`ifdef HOUR_12H_EN
      pm_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      day_wrap_q <= day_wrap_d;
`ifdef HOUR_12H_EN
      pm_q       <= pm_d;
`endif
    end
  end

  assign count    = count_q;
  assign day_wrap = day_wrap_q;

endmodule

// File: doc/hour_counter.md
HOUR_COUNTER -- requirements
Module: hour_counter

Interface
REQ-001 SHALL have parameter START_HOURS, default 8'h00, BCD hours value loaded on reset; must be a legal value for the compiled mode.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk only.
REQ-003 SHALL have port reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port en  input  1  hour-carry pulse from the minutes tens stage (its en_next); one-cycle-high means "advance one hour".
REQ-005 SHALL have port set_req  input  1  host request to load set_hours; held high until set_ack seen.
REQ-006 SHALL have port set_hours  input  8  BCD hours to load: [7:4] tens, [3:0] units; stable while set_req high.
REQ-007 SHALL have port set_ack  output  1  one-cycle pulse: load request processed.
REQ-008 SHALL have port set_err  output  1  one-cycle pulse coincident with set_ack when set_hours was illegal (no load).
REQ-009 SHALL have port count  output  8  current hours, BCD: [7:4] tens 0-2, [3:0] units 0-9.
REQ-010 SHALL have port day_wrap  output  1  one-cycle pulse on the cycle count rolls over to the start of day.

Function
REQ-011 SHALL run a 3-state handshake FSM: IDLE, LOAD, WAIT_REL.
REQ-012 IDLE -> LOAD when set_req sampled high; LOAD -> WAIT_REL after exactly one cycle; WAIT_REL -> IDLE when set_req sampled low.
REQ-013 In LOAD cycle: legal set_hours -> count <= set_hours, set_ack=1, set_err=0; illegal -> count unchanged, set_ack=1, set_err=1.
REQ-014 Legal (24h): tens 0-1 with units 0-9, or tens 2 with units 0-3; any nibble > 9 illegal.
REQ-015 Outside the LOAD cycle, en=1 advances count by one hour, one cycle latency (count updates on the edge sampling en).
REQ-016 Units increment 0..9; units 9 -> units 0, tens +1; 23 -> 00 (24h).
REQ-017 day_wrap SHALL be 1 for exactly the cycle after the edge that performs 23->00, else 0.
REQ-018 en coinciding with the LOAD cycle SHALL be dropped (load wins; no deferred carry).
REQ-019 en consecutive high cycles SHALL advance once per cycle (no edge detection).
REQ-020 set_req held high after WAIT_REL entry SHALL NOT trigger a second load; a new load needs set_req low then high.
REQ-021 count SHALL never hold an illegal BCD value in any state.

Reset
REQ-022 reset high SHALL immediately force count=START_HOURS, FSM=IDLE, set_ack=0, set_err=0, day_wrap=0 (and pm per REQ-025).
REQ-023 reset asserted mid-handshake SHALL abort it; after release, a still-high set_req SHALL start a fresh load from IDLE.
REQ-024 reset SHALL take priority over set and en.

Configuration
REQ-025 Macro HOUR_12H_EN defined: 12-hour mode; adds port pm  output  1  (1=PM) and port set_pm  input  1  (PM flag loaded with set_hours); reset value pm=0.
REQ-026 With HOUR_12H_EN: sequence 12,01..11,12; 11->12 toggles pm; day_wrap pulses on 11 PM -> 12 AM; legal set_hours 01-12 only; START_HOURS default treated as 8'h12.
REQ-027 Without HOUR_12H_EN: 24-hour mode, ports pm/set_pm absent, REQ-014/016 apply.

Verification
REQ-028 reset pulse, START_HOURS=8'h00 -> count=8'h00, day_wrap=0, set_ack=0 while reset high.
REQ-029 24 en pulses from 00 -> count steps 01..09,10..19,20..23,00; day_wrap=1 only on final step.
REQ-030 set_req with set_hours=8'h17 -> set_ack 1 cycle, set_err=0, count=8'h17; set_req held 5 cycles -> no second ack.
REQ-031 set_hours=8'h24 then 8'h1A -> set_ack+set_err each, count unchanged.
REQ-032 en and set_req(8'h05) same cycle at count 8'h09 -> count=8'h05, carry lost; reset asserted in WAIT_REL -> FSM IDLE, count=START_HOURS.
REQ-033 HOUR_12H_EN: from 11 AM one en -> 12 pm=1; from 11 PM one en -> 12 pm=0, day_wrap=1; set 8'h00 -> set_err.
